// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC hand-off path: reload-mode encoding,
// default gain constant, capture iteration and the {x, y, z} operand bundle.
package cordic_pkg;

  localparam int              WIDTH_DEF     = 16;
  localparam int              LAST_ITER_DEF = 10;
  localparam logic [15:0]     K_INIT_DEF    = 16'h04D4;

  // Reload modes: which CORDIC results seed the next chained pass
  localparam logic [1:0] MODE_AF_Y = 2'd0;  // X=K, Y=0, Z=yout
  localparam logic [1:0] MODE_AF_Z = 2'd1;  // X=K, Y=0, Z=zout
  localparam logic [1:0] MODE_VEC  = 2'd2;  // X=xout, Y=yout, Z=0
  localparam logic [1:0] MODE_PASS = 2'd3;  // X=xout, Y=yout, Z=zout

  typedef struct packed {
    logic [WIDTH_DEF-1:0] x;
    logic [WIDTH_DEF-1:0] y;
    logic [WIDTH_DEF-1:0] z;
  } reload_t;

endpackage

// File: rtl/handoff_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head entry is visible on
// pop_data whenever empty is low. A push into a full FIFO is accepted only with a pop.
module handoff_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_handoff_buffer.sv
// Captures CORDIC results once per sweep at LAST_ITER, builds the reload operand set
// for the next chained pass and queues it behind a valid/ready output handshake.
module cordic_handoff_buffer
  import cordic_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter int               ITER_W    = 4,
  parameter int               LAST_ITER = LAST_ITER_DEF,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] K_INIT    = K_INIT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        xout,
  input  logic [WIDTH-1:0]        yout,
  input  logic [WIDTH-1:0]        zout,
  input  logic [ITER_W-1:0]       iter,
  input  logic                    af_en,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        x_h,
  output logic [WIDTH-1:0]        y_h,
  output logic [WIDTH-1:0]        z_h,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int DATA_W = 3 * WIDTH;

  logic              armed;
  logic              at_last;
  logic              cap;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [WIDTH-1:0]  x_new;
  logic [WIDTH-1:0]  y_new;
  logic [WIDTH-1:0]  z_new;
  logic [DATA_W-1:0] head;

  assign at_last = af_en & (iter == ITER_W'(LAST_ITER));
  assign cap     = at_last & armed;

  // Handshake: out_valid means the head entry is presented on x_h/y_h/z_h;
  // it transfers on a cycle where out_valid and out_ready are both high, and
  // the head holds steady while out_valid is high and out_ready is low.
  assign pop  = out_valid & out_ready;
  assign push = cap & (~full | pop);

  // One capture per LAST_ITER dwell: disarm on capture, rearm once the dwell ends
  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (cap)           armed <= 1'b0;
      else if (!at_last) armed <= 1'b1;
      if (cap & full & ~pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    x_new = K_INIT;
    y_new = '0;
    z_new = '0;
    case (mode)
      MODE_AF_Y: z_new = yout;
      MODE_AF_Z: z_new = zout;
      MODE_VEC: begin
        x_new = xout;
        y_new = yout;
      end
      MODE_PASS: begin
        x_new = xout;
        y_new = yout;
        z_new = zout;
      end
      default: ;
    endcase
  end

  handoff_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({x_new, y_new, z_new}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = ~empty;
  assign x_h = out_valid ? head[3*WIDTH-1:2*WIDTH] : '0;
  assign y_h = out_valid ? head[2*WIDTH-1:WIDTH]   : '0;
  assign z_h = out_valid ? head[WIDTH-1:0]         : '0;

endmodule
